// File: rtl/scroll_scheduler.sv
// Frame-level scroll controller: issues one draw request per frame tick, waits for the
// draw subsystem, then advances the scroll offset and the seven-entry tile-row queue.
module scroll_scheduler #(
  parameter int unsigned FRAME_DIV = 833333,
  parameter int unsigned TILE_H    = 40,
  parameter int unsigned SPEED     = 1,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       all_draw_done,
  output logic       draw_go,
  output logic [5:0] offset,
  output logic [2:0] line_0,
  output logic [2:0] line_1,
  output logic [2:0] line_2,
  output logic [2:0] line_3,
  output logic [2:0] line_4,
  output logic [2:0] line_5,
  output logic [2:0] line_6,
  output logic       row_shift,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned     CNT_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_DIV - 1);
  localparam logic [6:0]      TILE_H7 = 7'(TILE_H);
  localparam logic [6:0]      SPEED7  = 7'(SPEED);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_GO,
    S_DRAWING,
    S_ADVANCE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       offset_q, offset_d;
  logic [2:0]       line_q [0:6];
  logic [2:0]       line_d [0:6];
  logic [7:0]       lfsr_q, lfsr_d;
  logic             row_shift_q, row_shift_d;
  logic             overrun_q, overrun_d;

  logic             tick;
  logic [6:0]       sum;
  logic             wrap;
  logic             in_frame;

  assign tick     = (cnt_q == CNT_MAX);
  assign sum      = {1'b0, offset_q} + SPEED7;
  assign wrap     = (sum >= TILE_H7);
  assign in_frame = (state_q == S_GO) || (state_q == S_DRAWING) || (state_q == S_ADVANCE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
    offset_d    = offset_q;
    line_d      = line_q;
    lfsr_d      = lfsr_q;
    row_shift_d = 1'b0;
    overrun_d   = overrun_q | (tick & enable & in_frame);

    case (state_q)
      S_IDLE:      if (enable) state_d = S_WAIT_TICK;
      S_WAIT_TICK: begin
        if (!enable)   state_d = S_IDLE;
        else if (tick) state_d = S_GO;
      end
      S_GO:        state_d = S_DRAWING;
      S_DRAWING:   if (all_draw_done) state_d = S_ADVANCE;
      S_ADVANCE: begin
        state_d = enable ? S_WAIT_TICK : S_IDLE;
        if (wrap) begin
          offset_d = 6'(sum - TILE_H7);
          for (int k = 1; k < 7; k++) line_d[k] = line_q[k-1];
          line_d[0]   = {1'b0, lfsr_q[1:0]};
          lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
          row_shift_d = 1'b1;
        end else begin
          offset_d = sum[5:0];
        end
      end
      default:     state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so all flops sample together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      offset_q    <= '0;
      lfsr_q      <= LFSR_SEED;
      row_shift_q <= 1'b0;
      overrun_q   <= 1'b0;
      // NOTE: the row queue is a handful of flops that the engines read directly, so it is reset.
      for (int k = 0; k < 7; k++) line_q[k] <= 3'b111;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      offset_q    <= offset_d;
      line_q      <= line_d;
      lfsr_q      <= lfsr_d;
      row_shift_q <= row_shift_d;
      overrun_q   <= overrun_d;
    end
  end

  // Moore outputs decode the state register, so reset clears them asynchronously.
  assign draw_go   = (state_q == S_GO);
  assign busy      = (state_q != S_IDLE) && (state_q != S_WAIT_TICK);
  assign offset    = offset_q;
  assign row_shift = row_shift_q;
  assign overrun   = overrun_q;
  assign line_0    = line_q[0];
  assign line_1    = line_q[1];
  assign line_2    = line_q[2];
  assign line_3    = line_q[3];
  assign line_4    = line_q[4];
  assign line_5    = line_q[5];
  assign line_6    = line_q[6];

endmodule

// File: doc/scroll_scheduler.md
# scroll_scheduler

Frame-level controller for the tile-drawing datapath. Generates the per-frame `draw_go` request, waits for the drawing subsystem's `all_draw_done`, then advances the scroll `offset`. On tile-row wrap it shifts the seven-entry row queue (`line_0`…`line_6`) and inserts a new pseudo-random row at the top. Sits between game control (`enable`) and the draw master, and owns all scroll state the draw/erase engines consume.

## Interface
- `FRAME_DIV`, 833333: clock cycles per frame tick (50 MHz / 60 Hz); ≥ 4.
- `TILE_H`, 40: tile row height in pixels (240 / 6); ≤ 63.
- `SPEED`, 1: pixels scrolled per completed frame; 1 ≤ SPEED ≤ TILE_H.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be non-zero.

Ports:
- `clock` in 1: system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: game running; scrolling occurs only while high.
- `all_draw_done` in 1: drawing subsystem finished the current frame; sampled only in DRAWING.
- `draw_go` out 1: one-cycle frame-draw request.
- `offset` out 6: vertical scroll offset, 0…TILE_H-1.
- `line_0`…`line_6` out 3 each: row queue, `line_0` at the top. 3'b0cc = tile in column cc; 3'b111 = empty row.
- `row_shift` out 1: one-cycle pulse coincident with a queue shift.
- `overrun` out 1: sticky; a frame tick was missed.
- `busy` out 1: high in every state except IDLE and WAIT_TICK.

## Operation
- **Tick counter:** free-running 0…FRAME_DIV-1 regardless of state. `tick` is asserted combinationally when count = FRAME_DIV-1.
- **FSM states:** IDLE, WAIT_TICK, GO, DRAWING, ADVANCE.
  - IDLE: go to WAIT_TICK when `enable`=1.
  - WAIT_TICK: if `enable`=0, go to IDLE; else on `tick`, go to GO.
  - GO: `draw_go`=1 (Moore output); unconditionally go to DRAWING.
  - DRAWING: hold until `all_draw_done`=1, then go to ADVANCE. `enable`=0 does not abort a draw in progress.
  - ADVANCE: update scroll state as below. Go to WAIT_TICK if `enable`=1, else IDLE.
- **Scroll update (ADVANCE):**
  - Form the 7-bit sum `s` = `offset` + SPEED.
  - If `s` ≥ TILE_H: `offset` ← `s` − TILE_H; `line_k` ← `line_(k−1)` for k = 6…1; `line_0` ← {1'b0, `lfsr`[1:0]}; LFSR steps; `row_shift` = 1 for one cycle.
  - Else: `offset` ← `s`; queue and LFSR unchanged.
  - The old `line_6` is discarded.
- **LFSR:** 8 bits. Next value = {`lfsr`[6:0], `lfsr`[7]^`lfsr`[5]^`lfsr`[4]^`lfsr`[3]}. Steps only on a row shift.
- **Overrun:** set when `tick`=1 in GO, DRAWING or ADVANCE while `enable`=1. The missed tick is dropped, not queued. Cleared only by `reset`.

## Timing
- **Reset values:** state IDLE, `draw_go`=0, `offset`=0, all `line_k`=3'b111, `row_shift`=0, `overrun`=0, `busy`=0, `lfsr`=LFSR_SEED, tick counter 0.
- **Latency:**
  - `tick` in cycle t → `draw_go` high in cycle t+1 only.
  - `all_draw_done` sampled high in cycle d → ADVANCE in d+1 → new `offset`, queue and `row_shift` visible in d+2.
  - Earliest next `draw_go` is at the following tick.
- **Throughput:** at most one `draw_go` per tick and exactly one ADVANCE per `draw_go`.
- **Output stability:** `offset` and `line_k` are registered and stable from `draw_go` until ADVANCE, so the engines see constant inputs for the whole draw.
- **Simultaneous events:** a `tick` in the same cycle as ADVANCE is missed (sets `overrun`); it is not carried into WAIT_TICK.
- **Mid-operation reset:** asserting `reset` in any state returns all outputs to reset values immediately and asynchronously. `draw_go` must never be high in the cycle after reset deasserts.

## Test plan
Simulation parameters: FRAME_DIV=16, TILE_H=40.

1. **Reset:** pulse `reset` mid-DRAWING → same cycle `offset`=0, `line_0..6`=3'b111, `draw_go`=0, `overrun`=0, `busy`=0.
2. **Single frame (SPEED=1):** `enable`=1; raise `all_draw_done` 5 cycles after `draw_go` → exactly one `draw_go` cycle, 1 cycle after `tick`; `offset` 0→1 two cycles after done; `row_shift`=0.
3. **Wrap (SPEED=8), done returned promptly:** over frames `offset` = 8, 16, 24, 32, then 0 on frame 5 with `row_shift`=1. Then `line_0`=3'b001, `line_1..6`=3'b111, `lfsr`=8'h4A. Frame 10 gives `line_0`=3'b010, `line_1`=3'b001.
4. **Overrun:** hold `all_draw_done`=0 for 40 cycles → `overrun`=1 after the 2nd tick; only one `draw_go` issued; release done → single ADVANCE, `offset`+SPEED.
5. **Enable drop mid-draw:** `enable`=0 during DRAWING → stays in DRAWING until done, performs ADVANCE, goes to IDLE; no further `draw_go` across 3 ticks.
6. **Re-enable:** `enable`=1 from IDLE → `draw_go` on the first subsequent tick; `offset` continues from its held value.
